fetch_ctrl: RTL

Program-counter and fetch sequencer for the 9-bit-instruction core. Owns the instruction address driven into the combinational instruction ROM and runs one program per Start/Ack handshake: launch at a given address, step sequentially, apply jump/branch redirects and stalls from the decoder, and stop on halt or on an out-of-range fetch. Sits between the top-level test harness (Start/Ack) and the ROM/decoder pair.

---
 rtl/fetch_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: launches a program on Start, steps/redirects
// the PC through a combinational ROM, and stops on halt or an out-of-range fetch.
module fetch_ctrl #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [AW-1:0]    StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             JumpEn,
  input  logic [AW-1:0]    JumpTarget,
  input  logic             BranchEn,
  input  logic [OFF_W-1:0] BranchOff,
  output logic [AW-1:0]    InstAddress,
  output logic             InstValid,
  output logic             Busy,
  output logic             Ack,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [AW-1:0]    pc;
  logic             fault;
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0]    next_pc;
  logic             next_oor;
  logic             start_oor;

  // Candidate next address; jump beats branch, arithmetic wraps mod 2^AW.
  always_comb begin
    next_pc = pc + AW'(1);
    if (JumpEn) begin
      next_pc = JumpTarget;
    end else if (BranchEn) begin
      next_pc = pc + AW'($signed(BranchOff));
    end
    next_oor  = (32'(next_pc) >= DEPTH);
    start_oor = (32'(StartAddr) >= DEPTH);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      fault <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            cnt <= '0;
            pc  <= StartAddr;
            if (start_oor) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              fault <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
          // Stalled cycles still count but ignore every decoder request.
          if (!Stall) begin
            if (Halt) begin
              state <= DONE;
            end else if (next_oor) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              pc <= next_pc;
            end
          end
        end
        DONE: begin
          if (!Start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign InstAddress = pc;
  assign Busy        = (state == RUN);
  assign InstValid   = (state == RUN) && !Stall;
  assign Ack         = (state == DONE);
  assign Fault       = fault;
  assign CycleCount  = cnt;

endmodule
